mem_bus_initiator: RTL and testbench
====================================

# mem_bus_initiator

Bus master that issues single and burst word transfers on the picorv32-native memory bus (valid/ready/addr/wdata/wstrb/rdata). Commands arrive on a valid/ready port, write data on a stream port, and read data leaves on a stream port. It sits beside the CPU as a second initiator into the address decode and mux, for example behind the UART loader path for host-driven memory inspection and loading.

## Interface
Parameters:
- LEN_WIDTH, 8, width of cmd_len; a burst is cmd_len+1 words (1..256 by default)
- TIMEOUT_CYCLES, 255, maximum cycles mem_valid may wait for mem_ready (only used with the timeout macro)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  start byte address; bits [1:0] are ignored and forced to 0
- cmd_len  in  LEN_WIDTH  words minus one
- cmd_wstrb  in  4  byte strobe for every word of a write burst
- wr_data_valid  in  1  write word offered
- wr_data_ready  out  1  high only in WDATA
- wr_data  in  32  write word
- rd_data_valid  out  1  read word available
- rd_data_ready  in  1  consumer accepts read word
- rd_data  out  32  read word, held stable while rd_data_valid is high
- done  out  1  one-cycle pulse at burst end
- error  out  1  one-cycle pulse with done when a burst is aborted by timeout
- mem_valid  out  1  bus request
- mem_instr  out  1  tied 0
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  0 for reads, latched cmd_wstrb for writes
- mem_ready  in  1  responder completes the transfer
- mem_rdata  in  32  read data, valid when mem_ready is high

## Operation
- FSM states: IDLE, WDATA, BUS, RESP, NEXT.
- IDLE: cmd_ready=1. On cmd_valid, latch addr (with [1:0]=0), count=cmd_len, the write flag and wstrb. Go to WDATA for a write, BUS for a read.
- WDATA: wr_data_ready=1. On wr_data_valid, latch wr_data into mem_wdata and go to BUS.
- BUS: mem_valid=1. mem_addr, mem_wdata and mem_wstrb stay stable until mem_ready.
  - On mem_ready with a read: register mem_rdata into rd_data and go to RESP.
  - On mem_ready with a write: go to NEXT.
- RESP: rd_data_valid=1 until rd_data_ready, then go to NEXT. Back-pressure is unlimited.
- NEXT: a mandatory gap cycle with mem_valid=0.
  - If count==0: pulse done and return to IDLE.
  - Otherwise: count-=1, addr+=4 (wraps modulo 2^32, 0xFFFF_FFFC -> 0x0000_0000), then go to WDATA or BUS.
- mem_ready is ignored in every state except BUS.
- cmd_valid outside IDLE is ignored. wr_data_valid outside WDATA is ignored.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE. rd_data=0, mem_addr=0.
- Reset mid-burst: the cycle after reset is sampled high, mem_valid=0, the FSM is in IDLE, and the burst is discarded with no done pulse.
- Read latency with a zero-wait responder:
  - cycle 0: command handshake.
  - cycle 1: mem_valid high; mem_ready is sampled in this same cycle.
  - cycle 2: rd_data_valid high.
  - cycle 3 (when rd_data_ready was already high in cycle 2): NEXT.
- Best case is 3 cycles per read word and 3 cycles per write word (WDATA, BUS, NEXT).
- mem_valid is never high in two consecutive transfers without the NEXT gap. This matches responders that register ready for one cycle.
- done is asserted in the NEXT cycle of the final word. cmd_ready rises the following cycle.
- The count is LEN_WIDTH bits; cmd_len all-ones yields 2^LEN_WIDTH words.

## Configuration
- MEM_BUS_INITIATOR_TIMEOUT_EN defined:
  - An 8..32-bit wait counter clears on entry to BUS and increments each BUS cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES, mem_valid drops and done and error pulse together next cycle. The FSM returns to IDLE and the remaining words are dropped.
  - No rd_data is produced for the aborted word. wr_data_ready is not reasserted for the remaining words.
- Not defined: BUS waits for mem_ready indefinitely, error is tied 0, and no counter is instantiated.

## Test plan
- Single read: cmd addr=0x0000_0013, len=0; responder returns 0xDEAD_BEEF after 2 wait cycles -> mem_addr=0x0000_0010, mem_wstrb=0, rd_data=0xDEAD_BEEF, done pulses once, error=0.
- Write burst: addr=0xC000_0000, len=3, wstrb=0xF, data 1,2,3,4 -> four transfers at 0xC000_0000/4/8/C with matching wdata, mem_valid low for ≥1 cycle between them, done after the 4th.
- Wrap and back-pressure: read addr=0xFFFF_FFF8, len=2, rd_data_ready low for 5 cycles per word -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rd_data is stable while stalled; no new mem_valid until accepted.
- Timeout (macro on, TIMEOUT_CYCLES=16): read len=1, responder never ready -> mem_valid drops after 16 cycles, done and error pulse together, rd_data_valid never rises, cmd_ready=1 the next cycle.
- Reset mid-burst: assert reset during BUS of word 2 of a 4-word write -> next cycle mem_valid=0, cmd_ready=1, no done; a new command then completes normally.
- Ignored inputs: pulse cmd_valid and wr_data_valid during a read burst -> no extra transfers, and the latched address and length are unchanged.

Source files
------------

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: second initiator on the picorv32-native memory bus.
// Accepts single/burst word read and write commands, streams write data in
// and read data out, and inserts a mandatory idle gap between transfers.
// Optional build macro MEM_BUS_INITIATOR_TIMEOUT_EN adds a bounded wait on
// mem_ready that aborts the burst with done+error; without it the bus waits
// indefinitely and error is tied low.

// Protocol checker: properties that must hold on the bus and stream ports.
module mem_bus_initiator_checker #(
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic        clk,
  input logic        reset,
  input logic        cmd_ready,
  input logic        mem_valid,
  input logic        mem_ready,
  input logic [31:0] mem_addr,
  input logic [31:0] mem_wdata,
  input logic [3:0]  mem_wstrb,
  input logic        rd_data_valid,
  input logic        rd_data_ready,
  input logic [31:0] rd_data,
  input logic        done,
  input logic        error
);

  // Configuration sanity: a zero-length count or zero timeout is meaningless.
  a_cfg: assert property (@(posedge clk) (LEN_WIDTH > 0) && (TIMEOUT_CYCLES > 0));

  // A pending request keeps address, data and strobes unchanged.
  a_bus_stable: assert property (@(posedge clk) disable iff (reset)
    (mem_valid && !mem_ready) |=> ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_wstrb)));

  // Every completed transfer is followed by a cycle with mem_valid low.
  a_bus_gap: assert property (@(posedge clk) disable iff (reset)
    (mem_valid && mem_ready) |=> !mem_valid);

  // A stalled read word stays offered and unchanged.
  a_rd_hold: assert property (@(posedge clk) disable iff (reset)
    (rd_data_valid && !rd_data_ready) |=> (rd_data_valid && $stable(rd_data)));

  // While accepting commands nothing else is in flight.
  a_idle_quiet: assert property (@(posedge clk) disable iff (reset)
    cmd_ready |-> (!mem_valid && !rd_data_valid && !done));

  // error is only ever reported together with done.
  a_err_done: assert property (@(posedge clk) disable iff (reset)
    error |-> done);

  // A finished burst returns to accepting commands on the next cycle.
  a_done_idle: assert property (@(posedge clk) disable iff (reset)
    done |=> cmd_ready);

endmodule

module mem_bus_initiator #(
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [3:0]           cmd_wstrb,
  input  logic                 wr_data_valid,
  output logic                 wr_data_ready,
  input  logic [31:0]          wr_data,
  output logic                 rd_data_valid,
  input  logic                 rd_data_ready,
  output logic [31:0]          rd_data,
  output logic                 done,
  output logic                 error,
  output logic                 mem_valid,
  output logic                 mem_instr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_BUS   = 3'd2,
    ST_RESP  = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  state_t               state_r;
  logic [31:0]          addr_r;
  logic [LEN_WIDTH-1:0] count_r;
  logic                 write_r;
  logic [3:0]           wstrb_r;
  logic [31:0]          wdata_r;
  logic [31:0]          rd_data_r;
  logic                 cmd_ready_r;
  logic                 wr_data_ready_r;
  logic                 rd_data_valid_r;
  logic                 done_r;
  logic                 mem_valid_r;
  logic                 timeout_s;
  logic                 last_word_s;

  assign last_word_s = (count_r == {LEN_WIDTH{1'b0}});

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
  localparam int WAIT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W   = (WAIT_RAW < 8) ? 8 : ((WAIT_RAW > 32) ? 32 : WAIT_RAW);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES > 1) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic              error_r;

  // Wait counter: zero outside BUS, counts BUS cycles without mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (state_r != ST_BUS) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (!mem_ready) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // The final allowed waiting cycle without mem_ready aborts the burst.
  assign timeout_s = (state_r == ST_BUS) && !mem_ready && (wait_cnt_r == WAIT_LAST);

  // error pulses in the same cycle as the abort's done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= timeout_s;
    end
  end

  assign error = error_r;
`else
  assign timeout_s = 1'b0;
  assign error     = 1'b0;
`endif

  // Burst sequencer: command accept, write data, bus transfer, read response, gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      addr_r          <= 32'h0000_0000;
      count_r         <= {LEN_WIDTH{1'b0}};
      write_r         <= 1'b0;
      wstrb_r         <= 4'b0000;
      wdata_r         <= 32'h0000_0000;
      rd_data_r       <= 32'h0000_0000;
      cmd_ready_r     <= 1'b1;
      wr_data_ready_r <= 1'b0;
      rd_data_valid_r <= 1'b0;
      done_r          <= 1'b0;
      mem_valid_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_r      <= {cmd_addr[31:2], 2'b00};
            count_r     <= cmd_len;
            write_r     <= cmd_write;
            wstrb_r     <= cmd_write ? cmd_wstrb : 4'b0000;
            cmd_ready_r <= 1'b0;
            if (cmd_write) begin
              wr_data_ready_r <= 1'b1;
              state_r         <= ST_WDATA;
            end else begin
              mem_valid_r <= 1'b1;
              state_r     <= ST_BUS;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WDATA: begin
          if (wr_data_valid) begin
            wdata_r         <= wr_data;
            wr_data_ready_r <= 1'b0;
            mem_valid_r     <= 1'b1;
            state_r         <= ST_BUS;
          end else begin
            state_r <= ST_WDATA;
          end
        end

        ST_BUS: begin
          if (timeout_s) begin
            // Abort: drop the remaining words and finish through the gap cycle.
            mem_valid_r <= 1'b0;
            count_r     <= {LEN_WIDTH{1'b0}};
            done_r      <= 1'b1;
            state_r     <= ST_NEXT;
          end else if (mem_ready) begin
            mem_valid_r <= 1'b0;
            if (write_r) begin
              done_r  <= last_word_s;
              state_r <= ST_NEXT;
            end else begin
              rd_data_r       <= mem_rdata;
              rd_data_valid_r <= 1'b1;
              state_r         <= ST_RESP;
            end
          end else begin
            state_r <= ST_BUS;
          end
        end

        ST_RESP: begin
          if (rd_data_ready) begin
            rd_data_valid_r <= 1'b0;
            done_r          <= last_word_s;
            state_r         <= ST_NEXT;
          end else begin
            state_r <= ST_RESP;
          end
        end

        ST_NEXT: begin
          done_r <= 1'b0;
          if (last_word_s) begin
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            count_r <= count_r - LEN_WIDTH'(1);
            addr_r  <= addr_r + 32'd4;
            if (write_r) begin
              wr_data_ready_r <= 1'b1;
              state_r         <= ST_WDATA;
            end else begin
              mem_valid_r <= 1'b1;
              state_r     <= ST_BUS;
            end
          end
        end

        default: begin
          state_r         <= ST_IDLE;
          cmd_ready_r     <= 1'b1;
          wr_data_ready_r <= 1'b0;
          rd_data_valid_r <= 1'b0;
          done_r          <= 1'b0;
          mem_valid_r     <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign wr_data_ready = wr_data_ready_r;
  assign rd_data_valid = rd_data_valid_r;
  assign rd_data       = rd_data_r;
  assign done          = done_r;
  assign mem_valid     = mem_valid_r;
  assign mem_instr     = 1'b0;
  assign mem_addr      = addr_r;
  assign mem_wdata     = wdata_r;
  assign mem_wstrb     = wstrb_r;

  mem_bus_initiator_checker #(
    .LEN_WIDTH      (LEN_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_checker (
    .clk           (clk),
    .reset         (reset),
    .cmd_ready     (cmd_ready),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .rd_data       (rd_data),
    .done          (done),
    .error         (error)
  );

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed testbench for mem_bus_initiator: per-cycle vector table for
// single read, write burst and ignored-input cases, plus hand-written
// sequences for address wrap with back-pressure, reset mid-burst and the
// optional timeout abort (MEM_BUS_INITIATOR_TIMEOUT_EN).
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_wstrb;
  logic        wr_data_valid, wr_data_ready;
  logic [31:0] wr_data;
  logic        rd_data_valid, rd_data_ready;
  logic [31:0] rd_data;
  logic        done, error;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  mem_bus_initiator #(.LEN_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wstrb(cmd_wstrb),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .done(done), .error(error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        rst;
    logic        cv;
    logic        cw;
    logic [31:0] ca;
    logic [7:0]  cl;
    logic [3:0]  cs;
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        mr;
    logic [31:0] md;
  } in_t;

  typedef struct packed {
    logic        cmd_ready;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        error;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t        vecs[$];
  in_t         cur_in;
  out_t        cur_exp;
  in_t         hi;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr;
  logic [31:0] held;
  logic        seen_done;

  task automatic push();
    vecs.push_back('{i: cur_in, o: cur_exp});
    cur_in = '0;
  endtask

  task automatic drive(input in_t v);
    reset = v.rst; cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca;
    cmd_len = v.cl; cmd_wstrb = v.cs; wr_data_valid = v.wv; wr_data = v.wd;
    rd_data_ready = v.rr; mem_ready = v.mr; mem_rdata = v.md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input out_t e);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(e.cmd_ready));
    check({tag, ".wr_ready"},  32'(wr_data_ready), 32'(e.wr_ready));
    check({tag, ".rd_valid"},  32'(rd_data_valid), 32'(e.rd_valid));
    check({tag, ".rd_data"},   rd_data, e.rd_data);
    check({tag, ".done"},      32'(done), 32'(e.done));
    check({tag, ".error"},     32'(error), 32'(e.error));
    check({tag, ".mem_valid"}, 32'(mem_valid), 32'(e.mem_valid));
    check({tag, ".mem_addr"},  mem_addr, e.mem_addr);
    check({tag, ".mem_wdata"}, mem_wdata, e.mem_wdata);
    check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(e.mem_wstrb));
    check({tag, ".mem_instr"}, 32'(mem_instr), 32'd0);
  endtask

  initial begin
    cur_in = '0;
    cur_exp = '0;
    hi = '0;
    hi.rst = 1'b1;
    drive(hi);

    // ---- reset: only cmd_ready high ----
    cur_in.rst = 1'b1; cur_exp.cmd_ready = 1'b1; push();
    cur_in.rst = 1'b1; push();

    // ---- single read at 0x13, two wait cycles ----
    cur_in.cv = 1'b1; cur_in.ca = 32'h0000_0013; cur_in.cl = 8'd0;
    cur_exp.cmd_ready = 1'b0; cur_exp.mem_valid = 1'b1; cur_exp.mem_addr = 32'h0000_0010; push();
    push();
    push();
    cur_in.mr = 1'b1; cur_in.md = 32'hDEAD_BEEF;
    cur_exp.mem_valid = 1'b0; cur_exp.rd_valid = 1'b1; cur_exp.rd_data = 32'hDEAD_BEEF; push();
    cur_in.mr = 1'b1; cur_in.md = 32'h1234_5678; push();
    cur_in.rr = 1'b1; cur_exp.rd_valid = 1'b0; cur_exp.done = 1'b1; push();
    cur_exp.done = 1'b0; cur_exp.cmd_ready = 1'b1; push();

    // ---- write burst 4 words at 0xC000_0000, responder always ready ----
    cur_in.cv = 1'b1; cur_in.cw = 1'b1; cur_in.ca = 32'hC000_0000; cur_in.cl = 8'd3;
    cur_in.cs = 4'hF; cur_in.mr = 1'b1;
    cur_exp.cmd_ready = 1'b0; cur_exp.wr_ready = 1'b1;
    cur_exp.mem_addr = 32'hC000_0000; cur_exp.mem_wstrb = 4'hF; push();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        cur_in.mr = 1'b1; push();
      end
      cur_in.wv = 1'b1; cur_in.wd = 32'(k + 1); cur_in.mr = 1'b1;
      cur_exp.wr_ready = 1'b0; cur_exp.mem_valid = 1'b1; cur_exp.mem_wdata = 32'(k + 1); push();
      cur_in.mr = 1'b1; cur_in.wv = 1'b1; cur_in.wd = 32'h0000_0099;
      cur_exp.mem_valid = 1'b0; cur_exp.done = (k == 3); push();
      cur_in.mr = 1'b1; cur_in.wv = 1'b1; cur_in.wd = 32'h0000_0077; cur_exp.done = 1'b0;
      if (k < 3) begin
        cur_exp.wr_ready = 1'b1; cur_exp.mem_addr = 32'hC000_0000 + 32'(4 * (k + 1));
      end else begin
        cur_exp.cmd_ready = 1'b1;
      end
      push();
    end

    // ---- read burst of 2 at 0x100 with stray cmd_valid / wr_data_valid ----
    cur_in.cv = 1'b1; cur_in.ca = 32'h0000_0100; cur_in.cl = 8'd1;
    cur_exp.cmd_ready = 1'b0; cur_exp.mem_valid = 1'b1;
    cur_exp.mem_addr = 32'h0000_0100; cur_exp.mem_wstrb = 4'h0; push();
    cur_in.cv = 1'b1; cur_in.cw = 1'b1; cur_in.ca = 32'h0000_5000; cur_in.cl = 8'd7;
    cur_in.wv = 1'b1; cur_in.wd = 32'h0000_AAAA; push();
    cur_in.mr = 1'b1; cur_in.md = 32'h0000_0011; cur_in.cv = 1'b1; cur_in.ca = 32'h0000_6000;
    cur_exp.mem_valid = 1'b0; cur_exp.rd_valid = 1'b1; cur_exp.rd_data = 32'h0000_0011; push();
    cur_in.rr = 1'b1; cur_in.cv = 1'b1; cur_in.wv = 1'b1; cur_exp.rd_valid = 1'b0; push();
    cur_in.cv = 1'b1; cur_in.cl = 8'd9; cur_in.wv = 1'b1;
    cur_exp.mem_valid = 1'b1; cur_exp.mem_addr = 32'h0000_0104; push();
    cur_in.mr = 1'b1; cur_in.md = 32'h0000_0022;
    cur_exp.mem_valid = 1'b0; cur_exp.rd_valid = 1'b1; cur_exp.rd_data = 32'h0000_0022; push();
    cur_in.rr = 1'b1; cur_exp.rd_valid = 1'b0; cur_exp.done = 1'b1; push();
    cur_exp.done = 1'b0; cur_exp.cmd_ready = 1'b1; push();

    // ---- apply the table ----
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].i);
      step();
      check_all($sformatf("v%0d", k), vecs[k].o);
    end

    // ---- wrap at 0xFFFF_FFF8 with 5 cycles of back-pressure per word ----
    hi = '0; hi.cv = 1'b1; hi.ca = 32'hFFFF_FFF8; hi.cl = 8'd2; hi.mr = 1'b1;
    drive(hi); step();
    exp_addr = 32'hFFFF_FFF8;
    check("wrap.valid0", 32'(mem_valid), 32'd1);
    check("wrap.addr0", mem_addr, exp_addr);
    for (int w = 0; w < 3; w++) begin
      hi = '0; hi.mr = 1'b1; hi.md = 32'hA000_0000 + 32'(w);
      drive(hi); step();
      held = 32'hA000_0000 + 32'(w);
      check($sformatf("wrap%0d.rdv", w), 32'(rd_data_valid), 32'd1);
      check($sformatf("wrap%0d.rdata", w), rd_data, held);
      for (int s = 0; s < 5; s++) begin
        hi.md = 32'h5555_0000 + 32'(s);
        drive(hi); step();
        check($sformatf("wrap%0d.stall%0d.rdv", w, s), 32'(rd_data_valid), 32'd1);
        check($sformatf("wrap%0d.stall%0d.rdata", w, s), rd_data, held);
        check($sformatf("wrap%0d.stall%0d.memv", w, s), 32'(mem_valid), 32'd0);
      end
      hi.rr = 1'b1; drive(hi); step();
      check($sformatf("wrap%0d.gap_memv", w), 32'(mem_valid), 32'd0);
      check($sformatf("wrap%0d.done", w), 32'(done), (w == 2) ? 32'd1 : 32'd0);
      hi.rr = 1'b0; drive(hi); step();
      exp_addr = exp_addr + 32'd4;
      if (w < 2) begin
        check($sformatf("wrap%0d.next_memv", w), 32'(mem_valid), 32'd1);
        check($sformatf("wrap%0d.next_addr", w), mem_addr, exp_addr);
      end else begin
        check("wrap.cmd_ready", 32'(cmd_ready), 32'd1);
        check("wrap.final_addr", mem_addr, 32'h0000_0000);
      end
    end

    // ---- reset during BUS of word 2 of a 4-word write ----
    hi = '0; hi.cv = 1'b1; hi.cw = 1'b1; hi.ca = 32'h0000_0040; hi.cl = 8'd3; hi.cs = 4'hF;
    drive(hi); step();
    check("rst.wr_ready0", 32'(wr_data_ready), 32'd1);
    hi = '0; hi.wv = 1'b1; hi.wd = 32'h0000_000A; drive(hi); step();
    check("rst.addr0", mem_addr, 32'h0000_0040);
    hi = '0; hi.mr = 1'b1; drive(hi); step();
    hi = '0; drive(hi); step();
    check("rst.wr_ready1", 32'(wr_data_ready), 32'd1);
    hi = '0; hi.wv = 1'b1; hi.wd = 32'h0000_000B; drive(hi); step();
    check("rst.memv1", 32'(mem_valid), 32'd1);
    check("rst.addr1", mem_addr, 32'h0000_0044);
    hi = '0; hi.rst = 1'b1; drive(hi); step();
    check("rst.memv", 32'(mem_valid), 32'd0);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0000_0000);
    seen_done = 1'b0;
    hi = '0; hi.mr = 1'b1; hi.wv = 1'b1; drive(hi);
    for (int c = 0; c < 4; c++) begin
      step();
      if (done || mem_valid) seen_done = 1'b1;
    end
    check("rst.quiet_after", 32'(seen_done), 32'd0);
    hi = '0; hi.cv = 1'b1; hi.cw = 1'b1; hi.ca = 32'h0000_0083; hi.cl = 8'd0; hi.cs = 4'h3;
    drive(hi); step();
    check("new.wr_ready", 32'(wr_data_ready), 32'd1);
    check("new.addr", mem_addr, 32'h0000_0080);
    check("new.wstrb", 32'(mem_wstrb), 32'h3);
    hi = '0; hi.wv = 1'b1; hi.wd = 32'h0000_0055; drive(hi); step();
    check("new.memv", 32'(mem_valid), 32'd1);
    check("new.wdata", mem_wdata, 32'h0000_0055);
    hi = '0; hi.mr = 1'b1; drive(hi); step();
    check("new.done", 32'(done), 32'd1);
    check("new.gap", 32'(mem_valid), 32'd0);
    hi = '0; drive(hi); step();
    check("new.cmd_ready", 32'(cmd_ready), 32'd1);
    check("new.done_clr", 32'(done), 32'd0);

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    // ---- timeout: responder never ready, 16-cycle limit ----
    begin
      int   n_hi;
      logic rdv_seen;
      logic dropped;
      hi = '0; hi.cv = 1'b1; hi.ca = 32'h0000_0200; hi.cl = 8'd1;
      drive(hi); step();
      check("to.memv0", 32'(mem_valid), 32'd1);
      n_hi = 1; rdv_seen = 1'b0; dropped = 1'b0;
      hi = '0; drive(hi);
      for (int c = 0; c < 64 && !dropped; c++) begin
        step();
        if (rd_data_valid) rdv_seen = 1'b1;
        if (mem_valid) n_hi++;
        else dropped = 1'b1;
      end
      check("to.dropped", 32'(dropped), 32'd1);
      check("to.cycles", 32'(n_hi), 32'd16);
      check("to.done", 32'(done), 32'd1);
      check("to.error", 32'(error), 32'd1);
      check("to.no_rdv", 32'(rdv_seen), 32'd0);
      step();
      check("to.cmd_ready", 32'(cmd_ready), 32'd1);
      check("to.done_clr", 32'(done), 32'd0);
      check("to.error_clr", 32'(error), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
